ex_alu_stage: RTL and testbench
===============================

EX_ALU_STAGE -- requirements
Module: ex_alu_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  synchronous discard of all held and incoming ops.
REQ-005 SHALL have port in_valid  input  1  upstream op present.
REQ-006 SHALL have port in_ready  output  1  stage can accept an op this cycle.
REQ-007 SHALL have port alu_control  input  4  op code from ALU control decoder.
REQ-008 SHALL have ports src_a, src_b  input  DATA_W  operands (two's complement).
REQ-009 SHALL have ports rd_addr  input  5 and reg_write  input  1  destination register and write enable.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts head entry.
REQ-012 SHALL have ports result  output  DATA_W, zero  output  1, overflow  output  1, illegal_op  output  1, out_rd_addr  output  5, out_reg_write  output  1.

Function
REQ-013 SHALL decode alu_control: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed, result 1 or 0); 1100 NOR; all other codes illegal.
REQ-014 SHALL compute ADD/SUB modulo 2^DATA_W; SLT SHALL use the true signed comparison, unaffected by subtraction overflow.
REQ-015 SHALL set overflow for ADD when src_a and src_b signs match and sum sign differs, and for SUB when signs differ and difference sign differs from src_a; 0 for all other ops.
REQ-016 SHALL, for an illegal code, produce result 0, illegal_op 1, overflow 0.
REQ-017 SHALL set zero = (result == 0), computed from the stored result.
REQ-018 SHALL force out_reg_write to 0 when overflow or illegal_op is 1; otherwise pass reg_write.
REQ-019 SHALL compute in the accept cycle and store result, flags, rd_addr and write enable in a 2-entry in-order FIFO.
REQ-020 SHALL accept an op when in_valid && in_ready; in_ready SHALL be 1 iff occupancy < 2, independent of out_ready in that cycle.
REQ-021 SHALL present the oldest entry on the outputs with out_valid = (occupancy > 0); it SHALL retire when out_valid && out_ready.
REQ-022 SHALL have 1-cycle latency: op accepted at edge N into an empty FIFO is visible with out_valid 1 after edge N.
REQ-023 SHALL hold all output fields stable while out_valid && !out_ready.
REQ-024 SHALL, on simultaneous accept and retire at occupancy 1, keep occupancy 1 with the new entry at the head after the edge.
REQ-025 SHALL, at occupancy 2, not accept (in_ready 0) even if out_ready is 1 that cycle; occupancy becomes 1 after retire.
REQ-026 SHALL wrap read/write pointers modulo 2 and preserve order across wrap.
REQ-027 SHALL, on flush, set occupancy 0 and drop any op offered that cycle; flush SHALL take priority over accept and retire.
REQ-028 SHALL drive output fields to 0 whenever out_valid is 0.

Reset
REQ-029 SHALL, on rst at a rising edge, set occupancy and pointers to 0, out_valid 0, in_ready 1 after the edge, all output fields 0.
REQ-030 SHALL give rst priority over flush, accept and retire; an op offered during rst SHALL be dropped, including mid-stall.

Verification
REQ-031 SHALL verify ADD 0x7FFFFFFF+0x00000001, rd 5, reg_write 1 -> next cycle result 0x80000000, overflow 1, out_reg_write 0, zero 0.
REQ-032 SHALL verify SUB 0x00000005-0x00000005 -> result 0, zero 1, overflow 0; SLT 0x80000000 vs 0x00000001 -> result 1.
REQ-033 SHALL verify code 1111 with reg_write 1 -> result 0, illegal_op 1, out_reg_write 0.
REQ-034 SHALL verify out_ready 0 with three back-to-back ops A,B,C -> in_ready 0 after A,B accepted, C held; release out_ready -> outputs A,B,C in order, each field stable while stalled.
REQ-035 SHALL verify occupancy 2 plus flush with in_valid 1 -> out_valid 0 and in_ready 1 after edge, offered op never appears.
REQ-036 SHALL verify rst asserted at occupancy 1 while an op is offered -> all outputs 0, out_valid 0 after edge, no entry emerges later.

Source files
------------

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: execute-stage ALU feeding a 2-entry in-order output FIFO.
// The ALU result is computed in the accept cycle and stored with its flags,
// destination register and write enable. The oldest entry drives the outputs.
module ex_alu_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [4:0]        rd_addr,
  input  logic              reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow,
  output logic              illegal_op,
  output logic [4:0]        out_rd_addr,
  output logic              out_reg_write
);

  localparam int MSB = DATA_W - 1;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_NOR = 4'b1100
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              overflow;
    logic              illegal_op;
    logic [4:0]        rd_addr;
    logic              reg_write;
  } entry_t;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  entry_t            alu_entry;

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push;
  logic       pop;
  entry_t     head;

  // ALU: decode the op code and build the entry to be stored on accept.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a value unassigned and no latch appears.
  always_comb begin
    sum       = src_a + src_b;
    diff      = src_a - src_b;
    alu_entry = '0;
    alu_entry.rd_addr = rd_addr;
    case (alu_op_e'(alu_control))
      OP_AND: alu_entry.result = src_a & src_b;
      OP_OR:  alu_entry.result = src_a | src_b;
      OP_NOR: alu_entry.result = ~(src_a | src_b);
      OP_ADD: begin
        alu_entry.result   = sum;
        alu_entry.overflow = (src_a[MSB] == src_b[MSB]) && (sum[MSB] != src_a[MSB]);
      end
      OP_SUB: begin
        alu_entry.result   = diff;
        alu_entry.overflow = (src_a[MSB] != src_b[MSB]) && (diff[MSB] != src_a[MSB]);
      end
      // True signed compare, so a wrapping subtraction cannot flip the answer.
      OP_SLT: alu_entry.result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_entry.illegal_op = 1'b1;
    endcase
    // Never let a faulting op update the register file.
    alu_entry.reg_write = reg_write && !alu_entry.overflow && !alu_entry.illegal_op;
  end

  assign in_ready = (count_q != 2'd2);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // FIFO next state: flush discards everything, including this cycle's offer.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = alu_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: reset wins over flush, accept and retire.
  // NOTE: sequential blocks use non-blocking '<=' so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  // NOTE: storage is deliberately not reset; an entry is only visible once
  // count_q says it was written, and empty outputs are forced to zero below.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Output view of the head entry, zeroed whenever the FIFO is empty.
  always_comb begin
    head          = mem_q[rd_ptr_q];
    out_valid     = (count_q != 2'd0);
    result        = '0;
    zero          = 1'b0;
    overflow      = 1'b0;
    illegal_op    = 1'b0;
    out_rd_addr   = '0;
    out_reg_write = 1'b0;
    if (out_valid) begin
      result        = head.result;
      zero          = (head.result == '0);
      overflow      = head.overflow;
      illegal_op    = head.illegal_op;
      out_rd_addr   = head.rd_addr;
      out_reg_write = head.reg_write;
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed testbench for ex_alu_stage with hand-computed expected values.
module tb_ex_alu_stage;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        alu_control;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [4:0]        rd_addr;
  logic              reg_write;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              overflow;
  logic              illegal_op;
  logic [4:0]        out_rd_addr;
  logic              out_reg_write;

  int n_checks = 0;
  int n_errors = 0;

  ex_alu_stage #(.DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_control   (alu_control),
    .src_a         (src_a),
    .src_b         (src_b),
    .rd_addr       (rd_addr),
    .reg_write     (reg_write),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero          (zero),
    .overflow      (overflow),
    .illegal_op    (illegal_op),
    .out_rd_addr   (out_rd_addr),
    .out_reg_write (out_reg_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rw);
    in_valid    = 1'b1;
    alu_control = ctl;
    src_a       = a;
    src_b       = b;
    rd_addr     = rd;
    reg_write   = rw;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    alu_control = 4'b0000;
    src_a       = '0;
    src_b       = '0;
    rd_addr     = '0;
    reg_write   = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] res, input logic z,
                             input logic ov, input logic ill, input logic [4:0] rd,
                             input logic rw);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " result"}, result, res);
    check({tag, " zero"}, 32'(zero), 32'(z));
    check({tag, " overflow"}, 32'(overflow), 32'(ov));
    check({tag, " illegal_op"}, 32'(illegal_op), 32'(ill));
    check({tag, " rd_addr"}, 32'(out_rd_addr), 32'(rd));
    check({tag, " reg_write"}, 32'(out_reg_write), 32'(rw));
  endtask

  task automatic expect_empty(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    check({tag, " result"}, result, 32'd0);
    check({tag, " zero"}, 32'(zero), 32'd0);
    check({tag, " overflow"}, 32'(overflow), 32'd0);
    check({tag, " illegal_op"}, 32'(illegal_op), 32'd0);
    check({tag, " rd_addr"}, 32'(out_rd_addr), 32'd0);
    check({tag, " reg_write"}, 32'(out_reg_write), 32'd0);
  endtask

  // One op through an empty FIFO: visible after one edge, retired on the next.
  task automatic run_single(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input logic rw,
                            input logic [31:0] res, input logic z, input logic ov,
                            input logic ill, input logic rw_exp);
    out_ready = 1'b0;
    drive(ctl, a, b, rd, rw);
    tick();
    idle();
    expect_head(tag, res, z, ov, ill, rd, rw_exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " retired"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle();
    tick();
    tick();
    expect_empty("reset");
    rst = 1'b0;

    // Single ops covering every legal code, overflow cases and illegal codes.
    run_single("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd5, 1'b1,
               32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_single("sub_zero", 4'b0110, 32'h0000_0005, 32'h0000_0005, 5'd6, 1'b1,
               32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    run_single("slt_neg", 4'b0111, 32'h8000_0000, 32'h0000_0001, 5'd7, 1'b1,
               32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    run_single("slt_pos", 4'b0111, 32'h0000_0001, 32'h8000_0000, 5'd8, 1'b1,
               32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    run_single("illegal_f", 4'b1111, 32'h1234_5678, 32'h1111_1111, 5'd9, 1'b1,
               32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_single("illegal_3", 4'b0011, 32'h7FFF_FFFF, 32'h0000_0001, 5'd10, 1'b1,
               32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_single("and", 4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd11, 1'b1,
               32'h00F0_000F, 1'b0, 1'b0, 1'b0, 1'b1);
    run_single("or", 4'b0001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd12, 1'b0,
               32'hFFF0_0FFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_single("nor", 4'b1100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd13, 1'b1,
               32'h000F_F000, 1'b0, 1'b0, 1'b0, 1'b1);
    run_single("sub_ovf", 4'b0110, 32'h8000_0000, 32'h0000_0001, 5'd14, 1'b1,
               32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    run_single("add_plain", 4'b0010, 32'h0000_0003, 32'h0000_0004, 5'd15, 1'b1,
               32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b1);
    run_single("add_neg", 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 1'b1,
               32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: A, B fill the FIFO, C waits; release drains A, B, C in order.
    out_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd2, 5'd1, 1'b1);           // A = 3
    tick();
    check("bp after A in_ready", 32'(in_ready), 32'd1);
    drive(4'b0001, 32'h10, 32'h01, 5'd2, 1'b1);          // B = 0x11
    tick();
    check("bp full in_ready", 32'(in_ready), 32'd0);
    drive(4'b0110, 32'd10, 32'd3, 5'd3, 1'b0);           // C = 7
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp stall in_ready", 32'(in_ready), 32'd0);
      expect_head("bp stall A", 32'd3, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1);
    end
    out_ready = 1'b1;                                    // full: retire only
    tick();
    check("bp after pop in_ready", 32'(in_ready), 32'd1);
    expect_head("bp head B", 32'h11, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
    tick();                                              // accept C, retire B
    idle();
    expect_head("bp head C", 32'd7, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0);
    check("bp occ1 in_ready", 32'(in_ready), 32'd1);
    tick();
    expect_empty("bp drained");
    out_ready = 1'b0;

    // Flush at occupancy 2 with a fresh op offered: everything disappears.
    drive(4'b0010, 32'd20, 32'd1, 5'd20, 1'b1);
    tick();
    drive(4'b0010, 32'd30, 32'd1, 5'd21, 1'b1);
    tick();
    check("flush pre in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    drive(4'b0010, 32'h100, 32'h23, 5'd22, 1'b1);
    tick();
    flush = 1'b0;
    idle();
    expect_empty("flush");
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush no ghost", 32'(out_valid), 32'd0);
    end
    run_single("post_flush", 4'b0010, 32'h100, 32'h23, 5'd23, 1'b1,
               32'h0000_0123, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset at occupancy 1 with an op offered.
    drive(4'b0001, 32'h55, 32'h0, 5'd24, 1'b1);
    tick();
    check("rst pre out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    drive(4'b0001, 32'h66, 32'h0, 5'd25, 1'b1);
    tick();
    rst = 1'b0;
    idle();
    expect_empty("rst occ1");
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst occ1 no ghost", 32'(out_valid), 32'd0);
    end

    // Reset mid-stall at occupancy 2 with an op offered.
    out_ready = 1'b0;
    drive(4'b0000, 32'hFF, 32'h0F, 5'd26, 1'b1);
    tick();
    tick();
    check("rst stall pre in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    expect_empty("rst stall");
    out_ready = 1'b1;
    tick();
    check("rst stall no ghost", 32'(out_valid), 32'd0);
    run_single("post_rst", 4'b0110, 32'd9, 32'd4, 5'd27, 1'b1,
               32'd5, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
